// File: rtl/audio_ctrl_fsm.sv
// Record/playback transport controller: key pulses and speed switches drive SRAM sequencing.
// Optional macro LOOP_PLAY_EN: end-of-play wraps to address 0 and keeps playing.
module audio_ctrl_fsm #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [17:0]       i_sw,
  input  logic              i_sample_tick,
  output logic [2:0]        o_state,
  output logic [ADDR_W-1:0] o_addr,
  output logic [4:0]        o_speed,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_wr_en,
  output logic              o_rd_en
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_HOLD = 3'd1, S_REC = 3'd2, S_PLAY = 3'd3, S_PAUSE = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr, r_end;
  logic [4:0]        r_speed;
  logic [2:0]        r_slow_cnt;
  logic              r_has_data;

  logic [4:0]        w_k_dec, w_speed_dec, w_k;
  logic [2:0]        w_km1;
  logic              w_slow, w_any_key, w_wr, w_rd, w_step_now, w_eop;
  logic [ADDR_W:0]   w_next;
  logic              w_unused_sw;

  assign w_unused_sw = ^{i_sw[16:9], i_sw[1:0]};

  // Highest selected switch wins; slow mode is the negated factor.
  always_comb begin
    w_k_dec = 5'd1;
    for (int n = 2; n <= 8; n++)
      if (i_sw[n]) w_k_dec = 5'(n);
    w_speed_dec = i_sw[17] ? w_k_dec : 5'(~w_k_dec + 5'd1);
  end

  assign w_slow     = r_speed[4];
  assign w_k        = w_slow ? 5'(~r_speed + 5'd1) : r_speed;
  assign w_km1      = 3'(w_k - 5'd1);
  assign w_any_key  = i_key_rec | i_key_play | i_key_stop;
  // Strobes are combinational so they line up with the address being accessed.
  assign w_wr       = !i_rst && (r_state == S_REC)  && i_sample_tick && !w_any_key;
  assign w_rd       = !i_rst && (r_state == S_PLAY) && i_sample_tick && !w_any_key;
  assign w_step_now = !w_slow || (r_slow_cnt == w_km1);
  assign w_next     = {1'b0, r_addr} + (ADDR_W+1)'(w_slow ? 5'd1 : w_k);
  assign w_eop      = w_next > {1'b0, r_end};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_end      <= '0;
      r_speed    <= 5'b00001;
      r_slow_cnt <= '0;
      r_has_data <= 1'b0;
    end else begin
      r_speed <= w_speed_dec;
      case (r_state)
        S_IDLE: begin
          r_addr <= '0;
          if (!i_key_stop && i_key_rec) r_state <= S_REC;
        end
        S_HOLD: begin
          r_addr <= '0;
          if (!i_key_stop && i_key_rec) r_state <= S_REC;
          else if (!i_key_stop && i_key_play) begin
            r_state    <= S_PLAY;
            r_slow_cnt <= '0;
          end
        end
        S_REC: begin
          if (i_key_stop) begin
            r_state <= r_has_data ? S_HOLD : S_IDLE;
            r_addr  <= '0;
          end else if (w_wr) begin
            r_end      <= r_addr;
            r_has_data <= 1'b1;
            if (r_addr == MAX_ADDR) begin
              r_state <= S_HOLD;
              r_addr  <= '0;
            end else r_addr <= r_addr + ADDR_W'(1);
          end
        end
        S_PLAY: begin
          if (i_key_stop) begin
            r_state <= S_HOLD;
            r_addr  <= '0;
          end else if (i_key_rec) begin
            r_state    <= S_REC;
            r_addr     <= '0;
            r_slow_cnt <= '0;
          end else if (i_key_play) r_state <= S_PAUSE;
          else if (w_rd) begin
            if (w_step_now) begin
              r_slow_cnt <= '0;
              if (w_eop) begin
                r_addr <= '0;
`ifdef LOOP_PLAY_EN
                r_state <= S_PLAY;
`else
                r_state <= S_HOLD;
`endif
              end else r_addr <= w_next[ADDR_W-1:0];
            end else r_slow_cnt <= r_slow_cnt + 3'd1;
          end
        end
        S_PAUSE: begin
          if (i_key_stop) begin
            r_state <= S_HOLD;
            r_addr  <= '0;
          end else if (i_key_rec) begin
            r_state    <= S_REC;
            r_addr     <= '0;
            r_slow_cnt <= '0;
          end else if (i_key_play) r_state <= S_PLAY;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_speed_dec != r_speed) r_slow_cnt <= '0;
    end
  end

  assign o_state    = r_state;
  assign o_addr     = r_addr;
  assign o_speed    = r_speed;
  assign o_end_addr = r_end;
  assign o_wr_en    = w_wr;
  assign o_rd_en    = w_rd;
endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// Directed bench for audio_ctrl_fsm; a second instance uses MAX_ADDR=7 for the full-memory case.
module tb_audio_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst, k_rec, k_play, k_stop, tick;
  logic [17:0] sw;
  logic [2:0]  state, state2;
  logic [19:0] addr, end_addr, addr2, end2;
  logic [4:0]  speed, speed2;
  logic        wr, rd, wr2, rd2;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  audio_ctrl_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_key_rec(k_rec), .i_key_play(k_play), .i_key_stop(k_stop),
    .i_sw(sw), .i_sample_tick(tick), .o_state(state), .o_addr(addr), .o_speed(speed),
    .o_end_addr(end_addr), .o_wr_en(wr), .o_rd_en(rd));

  audio_ctrl_fsm #(.ADDR_W(20), .MAX_ADDR(20'd7)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_key_rec(k_rec), .i_key_play(k_play), .i_key_stop(k_stop),
    .i_sw(sw), .i_sample_tick(tick), .o_state(state2), .o_addr(addr2), .o_speed(speed2),
    .o_end_addr(end2), .o_wr_en(wr2), .o_rd_en(rd2));

  // Inputs change on the falling edge; returns 1 time unit later so strobes can be sampled.
  task automatic drive(input logic r, input logic p, input logic s, input logic t);
    @(negedge clk);
    k_rec = r; k_play = p; k_stop = s; tick = t;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = '0;
    drive(0, 0, 0, 0); drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL rst_state got %0d want 0", state); end
    nvec++; if (addr !== 20'd0) begin nerr++; $display("FAIL rst_addr got %0d want 0", addr); end
    nvec++; if (end_addr !== 20'd0) begin nerr++; $display("FAIL rst_end got %0d want 0", end_addr); end
    nvec++; if (speed !== 5'b00001) begin nerr++; $display("FAIL rst_speed got %b want 00001", speed); end
    nvec++; if ({wr, rd} !== 2'b00) begin nerr++; $display("FAIL rst_strobes got %b want 00", {wr, rd}); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      nvec++; if ({wr, rd} !== 2'b00) begin nerr++; $display("FAIL idle_strobes got %b want 00", {wr, rd}); end
    end
    drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd0 || addr !== 20'd0) begin nerr++; $display("FAIL idle_play got st=%0d a=%0d want st=0 a=0", state, addr); end
  endtask

  task automatic test_record;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1);
      nvec++; if (wr !== 1'b1 || addr !== 20'(i)) begin nerr++; $display("FAIL rec_write got wr=%b a=%0d want wr=1 a=%0d", wr, addr, i); end
    end
    drive(0, 0, 1, 0); drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd1 || addr !== 20'd0) begin nerr++; $display("FAIL rec_stop got st=%0d a=%0d want st=1 a=0", state, addr); end
    nvec++; if (end_addr !== 20'd9) begin nerr++; $display("FAIL rec_end got %0d want 9", end_addr); end
  endtask

  task automatic test_fast;
    sw = 18'h0; sw[17] = 1'b1; sw[3] = 1'b1;
    drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    nvec++; if (speed !== 5'b00011) begin nerr++; $display("FAIL fast_speed got %b want 00011", speed); end
    nvec++; if (state !== 3'd3) begin nerr++; $display("FAIL fast_state got %0d want 3", state); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      nvec++; if (rd !== 1'b1 || addr !== 20'(3*i)) begin nerr++; $display("FAIL fast_addr got rd=%b a=%0d want rd=1 a=%0d", rd, addr, 3*i); end
    end
    drive(0, 0, 0, 0);
`ifdef LOOP_PLAY_EN
    nvec++; if (state !== 3'd3 || addr !== 20'd0) begin nerr++; $display("FAIL fast_eop got st=%0d a=%0d want st=3 a=0", state, addr); end
    drive(0, 0, 1, 0); drive(0, 0, 0, 0);
`else
    nvec++; if (state !== 3'd1 || addr !== 20'd0) begin nerr++; $display("FAIL fast_eop got st=%0d a=%0d want st=1 a=0", state, addr); end
`endif
  endtask

  task automatic test_slow_pause;
    sw = 18'h0; sw[2] = 1'b1;
    drive(0, 0, 0, 0); drive(0, 1, 0, 0); drive(0, 0, 0, 0);
    nvec++; if (speed !== 5'b11110) begin nerr++; $display("FAIL slow_speed got %b want 11110", speed); end
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1);
      nvec++; if (rd !== 1'b1 || addr !== 20'(i/2)) begin nerr++; $display("FAIL slow_addr got rd=%b a=%0d want rd=1 a=%0d", rd, addr, i/2); end
    end
    drive(0, 1, 0, 0);
    nvec++; if (addr !== 20'd4) begin nerr++; $display("FAIL pause_at got %0d want 4", addr); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      nvec++; if (state !== 3'd4 || rd !== 1'b0 || addr !== 20'd4) begin nerr++; $display("FAIL pause_hold got st=%0d rd=%b a=%0d want st=4 rd=0 a=4", state, rd, addr); end
    end
    drive(0, 1, 0, 0); drive(0, 0, 0, 1);
    nvec++; if (state !== 3'd3 || rd !== 1'b1 || addr !== 20'd4) begin nerr++; $display("FAIL resume got st=%0d rd=%b a=%0d want st=3 rd=1 a=4", state, rd, addr); end
    drive(0, 0, 0, 1); drive(0, 0, 0, 0);
    nvec++; if (addr !== 20'd5) begin nerr++; $display("FAIL resume_adv got %0d want 5", addr); end
  endtask

  task automatic test_stop_play_same;
    drive(0, 1, 1, 0); drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd1 || addr !== 20'd0) begin nerr++; $display("FAIL stop_play got st=%0d a=%0d want st=1 a=0", state, addr); end
  endtask

  task automatic test_max_addr;
    rst = 1'b1; drive(0, 0, 0, 0); rst = 1'b0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 1);
      if (i < 8) begin
        nvec++; if (wr2 !== 1'b1 || addr2 !== 20'(i)) begin nerr++; $display("FAIL max_write got wr=%b a=%0d want wr=1 a=%0d", wr2, addr2, i); end
      end else begin
        nvec++; if (wr2 !== 1'b0 || state2 !== 3'd1) begin nerr++; $display("FAIL max_full got wr=%b st=%0d want wr=0 st=1", wr2, state2); end
      end
    end
    nvec++; if (end2 !== 20'd7 || addr2 !== 20'd0) begin nerr++; $display("FAIL max_end got e=%0d a=%0d want e=7 a=0", end2, addr2); end
  endtask

  task automatic test_rst_mid_rec;
    rst = 1'b1; drive(0, 0, 0, 0); rst = 1'b0;
    drive(1, 0, 0, 0); drive(0, 0, 1, 0); drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL rec_empty_stop got %0d want 0", state); end
    drive(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    rst = 1'b1; drive(0, 0, 0, 1);
    nvec++; if (wr !== 1'b0) begin nerr++; $display("FAIL rst_wr got %b want 0", wr); end
    drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd0 || addr !== 20'd0 || end_addr !== 20'd0 || speed !== 5'b00001)
      begin nerr++; $display("FAIL rst_mid got st=%0d a=%0d e=%0d sp=%b want 0 0 0 00001", state, addr, end_addr, speed); end
    rst = 1'b0;
    drive(1, 0, 0, 0); drive(0, 0, 1, 1);
    nvec++; if (wr !== 1'b0) begin nerr++; $display("FAIL key_tick_wr got %b want 0", wr); end
    drive(0, 0, 0, 0);
    nvec++; if (state !== 3'd0) begin nerr++; $display("FAIL forgot_data got %0d want 0", state); end
  endtask

  initial begin
    rst = 1'b1; k_rec = 0; k_play = 0; k_stop = 0; tick = 0; sw = '0;
    test_reset;
    test_record;
    test_fast;
    test_slow_pause;
    test_stop_play_same;
    test_max_addr;
    test_rst_mid_rec;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
